// File: rtl/mb_sequencer.sv
// Math Box microcode sequencer: runs one microprogram per Begin_NOT start pulse, with step watchdog.
// Optional build macro MB_SINGLE_STEP_EN adds step_req to gate word advance in RUN.
module mb_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic              clk_6MHz,
    input  logic              Clear,
    input  logic              Begin_NOT,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              ucode_stop,
    input  logic              ucode_jump,
    input  logic [ADDR_W-1:0] ucode_jaddr,
`ifdef MB_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic [ADDR_W-1:0] ucode_addr,
    output logic              step_en,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS - 1);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [15:0]       cnt_r, cnt_s;
    logic              timeout_r, timeout_s;
    logic              step_s;

`ifdef MB_SINGLE_STEP_EN
    assign step_s = step_req;
`else
    assign step_s = 1'b1;
`endif

    // State, program counter, watchdog counter and sticky timeout registers.
    always_ff @(posedge clk_6MHz or negedge Clear) begin
        if (!Clear) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    // Next-state logic: restart beats stop, stop beats watchdog, watchdog beats jump.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
        case (state_r)
            IDLE, FIN: begin
                if (!Begin_NOT) begin
                    state_s   = RUN;
                    addr_s    = start_addr;
                    cnt_s     = 16'd0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!Begin_NOT) begin
                    addr_s    = start_addr;
                    cnt_s     = 16'd0;
                    timeout_s = 1'b0;
                end else if (step_s) begin
                    cnt_s = cnt_r + 16'd1;
                    if (ucode_stop) begin
                        state_s = FIN;
                    end else if (cnt_r == STEP_LIMIT) begin
                        state_s   = FIN;
                        timeout_s = 1'b1;
                    end else if (ucode_jump) begin
                        addr_s = ucode_jaddr;
                    end else begin
                        addr_s = addr_r + ADDR_W'(1);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign ucode_addr = addr_r;
    assign step_en    = (state_r == RUN) && step_s;
    assign busy       = (state_r == RUN);
    assign done       = (state_r == FIN);
    assign timeout    = timeout_r;

endmodule
